// File: rtl/tqvp_wdt_pkg.sv
// Shared definitions for the TinyQV watchdog and its heartbeat supervisor:
// register map, write-size encodings, controller states and bus decode.
package tqvp_wdt_pkg;

    localparam logic [5:0] WDT_ADDR_ENABLE    = 6'd0;
    localparam logic [5:0] WDT_ADDR_START     = 6'd1;
    localparam logic [5:0] WDT_ADDR_COUNTDOWN = 6'd2;
    localparam logic [5:0] WDT_ADDR_TAP       = 6'd3;
    localparam logic [5:0] WDT_ADDR_STATUS    = 6'd4;

    localparam logic [31:0] TAP_MAGIC_DEFAULT = 32'h0000ABCD;

    localparam logic [1:0] WSIZE_IDLE = 2'b11;
    localparam logic [1:0] WSIZE_B8   = 2'b00;
    localparam logic [1:0] WSIZE_B16  = 2'b01;
    localparam logic [1:0] WSIZE_B32  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_COUNT,
        ST_CFG_START,
        ST_RUN,
        ST_TAP,
        ST_FAULT,
        ST_DISABLE
    } hb_state_e;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [1:0]  writeN;
    } wdt_bus_t;

    // Each write-issuing state owns exactly one register write; all others leave the bus idle.
    function automatic wdt_bus_t busForState(input hb_state_e st,
                                             input logic [31:0] reload,
                                             input logic [31:0] magic);
        wdt_bus_t bus;
        bus.addr   = WDT_ADDR_ENABLE;
        bus.data   = 32'd0;
        bus.writeN = WSIZE_IDLE;
        case (st)
            ST_CFG_COUNT: begin
                bus.addr   = WDT_ADDR_COUNTDOWN;
                bus.data   = reload;
                bus.writeN = WSIZE_B32;
            end
            ST_CFG_START: begin
                bus.addr   = WDT_ADDR_START;
                bus.writeN = WSIZE_B32;
            end
            ST_TAP: begin
                bus.addr   = WDT_ADDR_TAP;
                bus.data   = magic;
                bus.writeN = WSIZE_B32;
            end
            ST_DISABLE: begin
                bus.addr   = WDT_ADDR_ENABLE;
                bus.writeN = WSIZE_B32;
            end
            default: ;
        endcase
        return bus;
    endfunction

endpackage

// File: rtl/tqvp_wdt_hb_collector.sv
// Per-window heartbeat bookkeeping: which requesters have checked in, which
// were absent at the last timeout, and whether the current window is complete.
module tqvp_wdt_hb_collector
    import tqvp_wdt_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] hb_req_i,
    input  logic [N_REQ-1:0] hb_mask_i,
    input  logic             clear_i,
    input  logic             clearMissed_i,
    input  logic             accumulate_i,
    input  logic             restart_i,
    input  logic             latchMissed_i,
    output logic [N_REQ-1:0] seen_o,
    output logic [N_REQ-1:0] missed_o,
    output logic             allSeen_o
);

    logic [N_REQ-1:0] seen_q, seen_d;
    logic [N_REQ-1:0] missed_q, missed_d;
    logic [N_REQ-1:0] maskedReq;

    assign maskedReq = hb_req_i & hb_mask_i;

    // Restart seeds the new window with pulses that arrive during the tap itself.
    always_comb begin
        seen_d = seen_q;
        if (clear_i) begin
            seen_d = '0;
        end else if (restart_i) begin
            seen_d = maskedReq;
        end else if (accumulate_i) begin
            seen_d = seen_q | maskedReq;
        end
    end

    always_comb begin
        missed_d = missed_q;
        if (clearMissed_i) begin
            missed_d = '0;
        end else if (latchMissed_i) begin
            missed_d = hb_mask_i & ~seen_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q   <= '0;
            missed_q <= '0;
        end else begin
            seen_q   <= seen_d;
            missed_q <= missed_d;
        end
    end

    // An empty mask never counts as complete, so the watchdog is left to expire.
    assign allSeen_o = (|hb_mask_i) && ((seen_q & hb_mask_i) == hb_mask_i);
    assign seen_o    = seen_q;
    assign missed_o  = missed_q;

endmodule

// File: rtl/tqvp_wdt_heartbeat_ctrl.sv
// Heartbeat supervisor driving the watchdog write port: configures the timer,
// taps it once all masked requesters check in, and records misses on timeout.
module tqvp_wdt_heartbeat_ctrl
    import tqvp_wdt_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter logic [31:0] WDT_RELOAD = 32'd1_000_000,
    parameter logic [31:0] TAP_MAGIC  = TAP_MAGIC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [N_REQ-1:0] hb_req_i,
    input  logic [N_REQ-1:0] hb_mask_i,
    input  logic             wdt_irq_i,
    output logic [5:0]       wdt_address_o,
    output logic [31:0]      wdt_data_o,
    output logic [1:0]       wdt_data_write_n_o,
    output logic             busy_o,
    output logic [N_REQ-1:0] seen_o,
    output logic [N_REQ-1:0] missed_o,
    output logic             fault_o,
    output logic [7:0]       tap_count_o
);

    if (WDT_RELOAD == 32'd0) begin : g_badReload
        $error("tqvp_wdt_heartbeat_ctrl: WDT_RELOAD must be nonzero");
    end
    if (N_REQ < 1 || N_REQ > 8) begin : g_badNReq
        $error("tqvp_wdt_heartbeat_ctrl: N_REQ must be in 1..8");
    end

    hb_state_e state_q;
    logic [7:0] tapCount_q;
    logic       allSeen;
    wdt_bus_t   bus;

    logic clearSeen, clearMissed, accumulate, restart, latchMissed;

    // Collector strobes mirror the RUN priority: disable, then timeout, then completion.
    always_comb begin
        clearSeen   = 1'b0;
        clearMissed = 1'b0;
        accumulate  = 1'b0;
        restart     = 1'b0;
        latchMissed = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clearSeen   = enable_i;
                clearMissed = enable_i;
            end
            ST_RUN: begin
                latchMissed = enable_i && wdt_irq_i;
                accumulate  = enable_i && !wdt_irq_i && !allSeen;
            end
            ST_TAP:     restart   = 1'b1;
            ST_DISABLE: clearSeen = 1'b1;
            default: ;
        endcase
    end

    tqvp_wdt_hb_collector #(
        .N_REQ (N_REQ)
    ) u_collector (
        .clk           (clk),
        .rst           (rst),
        .hb_req_i      (hb_req_i),
        .hb_mask_i     (hb_mask_i),
        .clear_i       (clearSeen),
        .clearMissed_i (clearMissed),
        .accumulate_i  (accumulate),
        .restart_i     (restart),
        .latchMissed_i (latchMissed),
        .seen_o        (seen_o),
        .missed_o      (missed_o),
        .allSeen_o     (allSeen)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tapCount_q <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_q    <= ST_CFG_COUNT;
                        tapCount_q <= 8'd0;
                    end
                end
                ST_CFG_COUNT: state_q <= ST_CFG_START;
                ST_CFG_START: state_q <= ST_RUN;
                ST_RUN: begin
                    if (!enable_i) begin
                        state_q <= ST_DISABLE;
                    end else if (wdt_irq_i) begin
                        state_q <= ST_FAULT;
                    end else if (allSeen) begin
                        state_q <= ST_TAP;
                    end
                end
                ST_TAP: begin
                    state_q <= ST_RUN;
                    if (tapCount_q != 8'hFF) begin
                        tapCount_q <= tapCount_q + 8'd1;
                    end
                end
                ST_FAULT: begin
                    if (!enable_i) begin
                        state_q <= ST_DISABLE;
                    end
                end
                ST_DISABLE: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Bus decodes from state_q alone, so async reset idles it without waiting for a clock.
    assign bus                = busForState(state_q, WDT_RELOAD, TAP_MAGIC);
    assign wdt_address_o      = bus.addr;
    assign wdt_data_o         = bus.data;
    assign wdt_data_write_n_o = bus.writeN;

    assign busy_o      = (state_q == ST_CFG_COUNT) || (state_q == ST_CFG_START) ||
                         (state_q == ST_TAP) || (state_q == ST_DISABLE);
    assign fault_o     = (state_q == ST_FAULT);
    assign tap_count_o = tapCount_q;

endmodule

// File: tb/tb_tqvp_wdt_heartbeat_ctrl.sv
// Self-checking bench for tqvp_wdt_heartbeat_ctrl: directed scenarios plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_tqvp_wdt_heartbeat_ctrl;

    localparam logic [31:0] RELOAD = 32'h0001_2345;
    localparam logic [31:0] MAGIC  = 32'h0000ABCD;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  hbReq;
    logic [3:0]  hbMask;
    logic        wdtIrq;
    logic [5:0]  wdtAddress;
    logic [31:0] wdtData;
    logic [1:0]  wdtWriteN;
    logic        busy;
    logic [3:0]  seen;
    logic [3:0]  missed;
    logic        fault;
    logic [7:0]  tapCount;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Model phases: what the supervisor is doing this cycle.
    localparam int P_IDLE = 0, P_WRITE_COUNT = 1, P_WRITE_START = 2, P_WATCH = 3,
                   P_WRITE_TAP = 4, P_TIMED_OUT = 5, P_WRITE_OFF = 6;
    int         mPhase;
    logic [3:0] mSeen;
    logic [3:0] mMissed;
    int         mTaps;

    tqvp_wdt_heartbeat_ctrl #(
        .N_REQ      (4),
        .WDT_RELOAD (RELOAD),
        .TAP_MAGIC  (MAGIC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable_i           (enable),
        .hb_req_i           (hbReq),
        .hb_mask_i          (hbMask),
        .wdt_irq_i          (wdtIrq),
        .wdt_address_o      (wdtAddress),
        .wdt_data_o         (wdtData),
        .wdt_data_write_n_o (wdtWriteN),
        .busy_o             (busy),
        .seen_o             (seen),
        .missed_o           (missed),
        .fault_o            (fault),
        .tap_count_o        (tapCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase  = P_IDLE;
        mSeen   = 4'd0;
        mMissed = 4'd0;
        mTaps   = 0;
    endtask

    task automatic modelEdge(input logic en, input logic [3:0] req,
                             input logic [3:0] mask, input logic irq);
        case (mPhase)
            P_IDLE: if (en) begin
                mPhase  = P_WRITE_COUNT;
                mSeen   = 4'd0;
                mMissed = 4'd0;
                mTaps   = 0;
            end
            P_WRITE_COUNT: mPhase = P_WRITE_START;
            P_WRITE_START: mPhase = P_WATCH;
            P_WATCH: begin
                if (!en) mPhase = P_WRITE_OFF;
                else if (irq) begin
                    mPhase  = P_TIMED_OUT;
                    mMissed = mask & ~mSeen;
                end else if (mask != 0 && (mSeen & mask) == mask) mPhase = P_WRITE_TAP;
                else mSeen = mSeen | (req & mask);
            end
            P_WRITE_TAP: begin
                mSeen  = req & mask;
                mTaps  = (mTaps < 255) ? mTaps + 1 : 255;
                mPhase = P_WATCH;
            end
            P_TIMED_OUT: if (!en) mPhase = P_WRITE_OFF;
            default: begin
                mSeen  = 4'd0;
                mPhase = P_IDLE;
            end
        endcase
    endtask

    task automatic checkAll();
        logic [5:0]  eAddr;
        logic [31:0] eData;
        logic [1:0]  eWn;
        eAddr = 6'd0;
        eData = 32'd0;
        eWn   = 2'b10;
        case (mPhase)
            P_WRITE_COUNT: begin eAddr = 6'd2; eData = RELOAD; end
            P_WRITE_START: eAddr = 6'd1;
            P_WRITE_TAP:   begin eAddr = 6'd3; eData = MAGIC; end
            P_WRITE_OFF:   ;
            default:       eWn = 2'b11;
        endcase
        checkOutput("addr", 32'(wdtAddress), 32'(eAddr));
        checkOutput("data", wdtData, eData);
        checkOutput("writeN", 32'(wdtWriteN), 32'(eWn));
        checkOutput("busy", 32'(busy), 32'(eWn == 2'b10));
        checkOutput("fault", 32'(fault), 32'(mPhase == P_TIMED_OUT));
        checkOutput("seen", 32'(seen), 32'(mSeen));
        checkOutput("missed", 32'(missed), 32'(mMissed));
        checkOutput("tapCount", 32'(tapCount), 32'(mTaps));
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] req,
                                 input logic [3:0] mask, input logic irq);
        enable = en;
        hbReq  = req;
        hbMask = mask;
        wdtIrq = irq;
        @(posedge clk);
        modelEdge(en, req, mask, irq);
        #1;
        checkAll();
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        hbReq  = 4'd0;
        hbMask = 4'd0;
        wdtIrq = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        checkOutput("resetWriteN", 32'(wdtWriteN), 32'h3);
        rst = 1'b0;

        // Configuration sequence
        applyStimulus(1, 4'd0, 4'hF, 0);
        checkOutput("cfgCountAddr", 32'(wdtAddress), 32'd2);
        checkOutput("cfgCountData", wdtData, RELOAD);
        applyStimulus(1, 4'd0, 4'hF, 0);
        checkOutput("cfgStartAddr", 32'(wdtAddress), 32'd1);
        applyStimulus(1, 4'd0, 4'hF, 0);
        checkOutput("runBusy", 32'(busy), 32'd0);

        // Full window leading to a single tap
        applyStimulus(1, 4'b0001, 4'hF, 0);
        applyStimulus(1, 4'b0010, 4'hF, 0);
        applyStimulus(1, 4'b0100, 4'hF, 0);
        applyStimulus(1, 4'b1000, 4'hF, 0);
        applyStimulus(1, 4'b0000, 4'hF, 0);
        checkOutput("tapAddr", 32'(wdtAddress), 32'd3);
        checkOutput("tapData", wdtData, 32'h0000ABCD);
        applyStimulus(1, 4'b0000, 4'hF, 0);
        checkOutput("tapCountOne", 32'(tapCount), 32'd1);
        checkOutput("seenAfterTap", 32'(seen), 32'd0);

        // Repeated pulses from one requester never complete a window
        repeat (3) applyStimulus(1, 4'b0001, 4'hF, 0);
        repeat (2) applyStimulus(1, 4'b0000, 4'hF, 0);
        checkOutput("seenIdempotent", 32'(seen), 32'b0001);

        // Timeout with partial check-in, then disable
        applyStimulus(1, 4'b0010, 4'hF, 0);
        applyStimulus(1, 4'b0000, 4'hF, 1);
        checkOutput("faultSet", 32'(fault), 32'd1);
        checkOutput("missedPartial", 32'(missed), 32'b1100);
        applyStimulus(1, 4'b0001, 4'hF, 0);
        checkOutput("faultNoWrite", 32'(wdtWriteN), 32'h3);
        applyStimulus(0, 4'b0000, 4'hF, 0);
        checkOutput("disableAddr", 32'(wdtAddress), 32'd0);
        checkOutput("disableWriteN", 32'(wdtWriteN), 32'h2);
        applyStimulus(0, 4'b0000, 4'hF, 0);
        checkOutput("missedRetained", 32'(missed), 32'b1100);

        // Timeout coincident with completion, then pulse carried across a tap
        repeat (3) applyStimulus(1, 4'b0000, 4'b0101, 0);
        applyStimulus(1, 4'b0001, 4'b0101, 0);
        applyStimulus(1, 4'b0100, 4'b0101, 0);
        applyStimulus(1, 4'b0000, 4'b0101, 1);
        checkOutput("faultWins", 32'(fault), 32'd1);
        applyStimulus(0, 4'b0000, 4'b0101, 0);
        applyStimulus(0, 4'b0000, 4'b0101, 0);
        repeat (3) applyStimulus(1, 4'b0000, 4'b0101, 0);
        applyStimulus(1, 4'b0101, 4'b0101, 0);
        applyStimulus(1, 4'b0000, 4'b0101, 0);
        checkOutput("tapAgainAddr", 32'(wdtAddress), 32'd3);
        applyStimulus(1, 4'b0001, 4'b0101, 0);
        checkOutput("carriedSeen", 32'(seen), 32'b0001);

        // Asynchronous reset in the middle of configuration
        applyStimulus(0, 4'b0000, 4'hF, 0);
        applyStimulus(0, 4'b0000, 4'hF, 0);
        applyStimulus(1, 4'b0000, 4'hF, 0);
        applyStimulus(1, 4'b0000, 4'hF, 0);
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        checkOutput("asyncIdle", 32'(wdtWriteN), 32'h3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkAll();
        applyStimulus(1, 4'b0000, 4'b0001, 0);
        checkOutput("restartCfg", 32'(wdtAddress), 32'd2);
        repeat (2) applyStimulus(1, 4'b0000, 4'b0001, 0);

        // Saturation of the tap counter
        for (int w = 0; w < 262; w++) begin
            applyStimulus(1, 4'b0001, 4'b0001, 0);
            applyStimulus(1, 4'b0001, 4'b0001, 0);
        end
        checkOutput("tapSaturated", 32'(tapCount), 32'd255);

        // Randomized traffic
        for (int i = 0; i < 700; i++) begin
            logic en, irq;
            logic [3:0] req, mask;
            en   = ($urandom_range(0, 99) < 96);
            irq  = ($urandom_range(0, 99) < 3);
            mask = 4'($urandom_range(0, 15));
            req  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            applyStimulus(en, req, mask, irq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
